conv_job_sequencer: RTL and testbench
=====================================

Name: conv_job_sequencer

Overview:
Top-level job controller and memory-port arbiter for the convolution core. It latches the job configuration and owns the X, Y and Z memory ports while idle, so the host can load operands and read results. It hands those ports to the core for one run and issues the core start pulse. It tracks completion, checks the result count and exposes sticky status plus an interrupt pulse.

Parameters:
DATA_WIDTH, 8, operand width; Z is 2*DATA_WIDTH.
ADDR_WIDTH, 5, X/Y address width; Z address is ADDR_WIDTH+1.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
host_cfg_wr  in  1  pulse; latch host_sizeX/host_sizeY.
host_sizeX  in  ADDR_WIDTH  length of X.
host_sizeY  in  ADDR_WIDTH  length of Y.
host_start  in  1  pulse; launch job.
host_clr  in  1  pulse; clear done_sticky/err_sticky.
host_req  in  1  single-cycle memory access request.
host_we  in  1  1=write, 0=read.
host_sel  in  2  0=X, 1=Y, 2=Z, 3=reserved.
host_addr  in  ADDR_WIDTH+1  access address (X/Y use low ADDR_WIDTH bits).
host_wdata  in  DATA_WIDTH  write data.
host_rdata  out  2*DATA_WIDTH  read data (X/Y zero-extended).
host_ack  out  1  access complete.
host_nak  out  1  access rejected; valid with host_ack.
busy  out  1  job in progress.
done_sticky  out  1  job finished.
err_sticky  out  1  bad config or Z-count mismatch.
irq  out  1  one-cycle completion pulse.
core_start  out  1  start pulse to core.
core_config  out  2*ADDR_WIDTH  {sizeY,sizeX}.
core_busy, core_done  in  1  core status.
core_memX_addr, core_memY_addr  in  ADDR_WIDTH  core addresses.
core_memZ_addr  in  ADDR_WIDTH+1  core Z address.
core_dataZ  in  2*DATA_WIDTH; core_writeZ  in  1  core Z write.
core_dataX, core_dataY  out  DATA_WIDTH  read data to core.
memX_addr/memX_we/memX_wdata/memX_rdata  out/out/out/in  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH  X memory port, synchronous read, 1-cycle latency; memY_* identical.
memZ_addr/memZ_we/memZ_wdata/memZ_rdata  out/out/out/in  ADDR_WIDTH+1/1/2*DATA_WIDTH/2*DATA_WIDTH  Z memory port.

Behaviour:
- Reset values: all outputs 0; config register 0; FSM in IDLE; zcount 0.
- FSM states: IDLE, START, RUN, FINISH.
- IDLE:
  - Host owns all memory ports.
  - host_cfg_wr latches sizes.
  - host_start with latched sizeX==0 or sizeY==0: set err_sticky and stay in IDLE.
  - Otherwise go to START; clear done_sticky, err_sticky and zcount.
- Same-cycle host_cfg_wr and host_start: the config is latched first, and start uses the new sizes.
- START: core_start=1 for exactly one cycle; core owns the ports; busy=1; next state RUN.
- RUN: busy=1. On core_done go to FINISH. Every core_writeZ increments zcount (ADDR_WIDTH+1 bits, saturating at all-ones).
- FINISH (1 cycle):
  - busy=0, irq=1, done_sticky set.
  - err_sticky set if zcount != sizeX+sizeY-1, computed at ADDR_WIDTH+1 bits.
  - A core_writeZ in this cycle still counts.
  - Next state IDLE.
- Port mux (combinational):
  - In START/RUN: memX/memY addr = core addresses with we=0; memZ addr/we/wdata = core signals; core_dataX/Y = memX/Y_rdata.
  - Otherwise: memory ports are driven from the host path, with core_data* = 0.
- Host access:
  - A host_req is accepted only if it is sampled in IDLE, host_sel != 3, and it is not a Z write.
  - Accepted access: the port is driven in the request cycle. host_ack=1 the next cycle, with host_rdata = registered memory output and host_nak=0.
  - Rejected access: no memory side effect; host_ack=1 and host_nak=1 the next cycle.
  - host_req in the same cycle as host_start in IDLE is accepted.
- host_cfg_wr and host_start outside IDLE are ignored; core_config is stable for the whole job.
- host_clr clears both stickies. If it coincides with a set event in FINISH, the set wins.
- core_done outside RUN is ignored.
- rst mid-job returns to IDLE and clears all state. The core shares rst.

Test Plan:
- Config sizeX=4, sizeY=3, start; model core issues 6 Z writes then core_done -> core_start pulse 1 cycle after start, busy high through RUN, irq one cycle, done_sticky=1, err_sticky=0.
- Host writes X[0..3]=1,2,3,4 and reads X[2] in IDLE -> ack 1 cycle after each req, read returns 0x0003, nak=0.
- Host read of X during RUN, and host Z write during IDLE -> ack=1, nak=1, memX_we/memZ_we never asserted by host.
- Start with sizeY=0 -> err_sticky=1, no core_start, stays IDLE; host_clr -> err_sticky=0.
- Core model issues only 5 Z writes for 4x3 -> done_sticky=1, err_sticky=1; host_clr same cycle as FINISH -> stickies remain set.
- rst asserted mid-RUN -> busy, stickies, irq drop to 0 immediately; next start runs normally.

Source files
------------

// File: rtl/conv_job_sequencer.sv
// Job controller for the convolution core: latches the job size, arbitrates the
// X/Y/Z memory ports between host and core, and reports completion status.
module conv_job_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_cfg_wr,
  input  logic [ADDR_WIDTH-1:0]     host_sizeX,
  input  logic [ADDR_WIDTH-1:0]     host_sizeY,
  input  logic                      host_start,
  input  logic                      host_clr,
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [1:0]                host_sel,
  input  logic [ADDR_WIDTH:0]       host_addr,
  input  logic [DATA_WIDTH-1:0]     host_wdata,
  output logic [2*DATA_WIDTH-1:0]   host_rdata,
  output logic                      host_ack,
  output logic                      host_nak,
  output logic                      busy,
  output logic                      done_sticky,
  output logic                      err_sticky,
  output logic                      irq,
  output logic                      core_start,
  output logic [2*ADDR_WIDTH-1:0]   core_config,
  input  logic                      core_busy,
  input  logic                      core_done,
  input  logic [ADDR_WIDTH-1:0]     core_memX_addr,
  input  logic [ADDR_WIDTH-1:0]     core_memY_addr,
  input  logic [ADDR_WIDTH:0]       core_memZ_addr,
  input  logic [2*DATA_WIDTH-1:0]   core_dataZ,
  input  logic                      core_writeZ,
  output logic [DATA_WIDTH-1:0]     core_dataX,
  output logic [DATA_WIDTH-1:0]     core_dataY,
  output logic [ADDR_WIDTH-1:0]     memX_addr,
  output logic                      memX_we,
  output logic [DATA_WIDTH-1:0]     memX_wdata,
  input  logic [DATA_WIDTH-1:0]     memX_rdata,
  output logic [ADDR_WIDTH-1:0]     memY_addr,
  output logic                      memY_we,
  output logic [DATA_WIDTH-1:0]     memY_wdata,
  input  logic [DATA_WIDTH-1:0]     memY_rdata,
  output logic [ADDR_WIDTH:0]       memZ_addr,
  output logic                      memZ_we,
  output logic [2*DATA_WIDTH-1:0]   memZ_wdata,
  input  logic [2*DATA_WIDTH-1:0]   memZ_rdata
);

  localparam int ZA = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FINISH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] size_x;
  logic [ADDR_WIDTH-1:0] size_y;
  logic [ZA-1:0]         zcount;
  logic                  rd_p1;
  logic [1:0]            sel_p1;

  logic                  core_owns;
  logic                  is_idle;
  logic                  host_ok;
  logic [ADDR_WIDTH-1:0] eff_x;
  logic [ADDR_WIDTH-1:0] eff_y;
  logic                  cfg_bad;
  logic [ZA-1:0]         exp_zcount;
  logic [ZA-1:0]         zcount_fin;
  logic                  unused_core_busy;

  function automatic logic [ZA-1:0] sat_inc(input logic [ZA-1:0] v);
    return (&v) ? v : v + ZA'(1);
  endfunction

  assign unused_core_busy = core_busy;
  assign core_config      = {size_y, size_x};
  assign core_owns        = (state == S_START) || (state == S_RUN);
  assign is_idle          = (state == S_IDLE);
  assign host_ok          = host_req && is_idle && (host_sel != 2'd3) &&
                            !(host_we && (host_sel == 2'd2));
  // A config write in the start cycle is seen by that start.
  assign eff_x            = host_cfg_wr ? host_sizeX : size_x;
  assign eff_y            = host_cfg_wr ? host_sizeY : size_y;
  assign cfg_bad          = (eff_x == '0) || (eff_y == '0);
  assign exp_zcount       = ZA'(size_x) + ZA'(size_y) - ZA'(1);
  assign zcount_fin       = core_writeZ ? sat_inc(zcount) : zcount;

  always_comb begin
    memX_addr  = host_addr[ADDR_WIDTH-1:0];
    memX_we    = host_ok && host_we && (host_sel == 2'd0);
    memX_wdata = host_wdata;
    memY_addr  = host_addr[ADDR_WIDTH-1:0];
    memY_we    = host_ok && host_we && (host_sel == 2'd1);
    memY_wdata = host_wdata;
    memZ_addr  = host_addr;
    memZ_we    = 1'b0;
    memZ_wdata = '0;
    core_dataX = '0;
    core_dataY = '0;
    if (core_owns) begin
      memX_addr  = core_memX_addr;
      memX_we    = 1'b0;
      memX_wdata = '0;
      memY_addr  = core_memY_addr;
      memY_we    = 1'b0;
      memY_wdata = '0;
      memZ_addr  = core_memZ_addr;
      memZ_we    = core_writeZ;
      memZ_wdata = core_dataZ;
      core_dataX = memX_rdata;
      core_dataY = memY_rdata;
    end
  end

  // Read data comes straight from the memory's output register in the ack cycle.
  always_comb begin
    host_rdata = '0;
    if (rd_p1) begin
      case (sel_p1)
        2'd0:    host_rdata = {{DATA_WIDTH{1'b0}}, memX_rdata};
        2'd1:    host_rdata = {{DATA_WIDTH{1'b0}}, memY_rdata};
        default: host_rdata = memZ_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      size_x      <= '0;
      size_y      <= '0;
      zcount      <= '0;
      rd_p1       <= 1'b0;
      sel_p1      <= 2'd0;
      host_ack    <= 1'b0;
      host_nak    <= 1'b0;
      busy        <= 1'b0;
      done_sticky <= 1'b0;
      err_sticky  <= 1'b0;
      irq         <= 1'b0;
      core_start  <= 1'b0;
    end else begin
      // ---- host access response stage
      host_ack <= host_req;
      host_nak <= host_req && !host_ok;
      rd_p1    <= host_ok && !host_we;
      sel_p1   <= host_sel;

      // Clear first so a same-cycle set event below takes priority.
      if (host_clr) begin
        done_sticky <= 1'b0;
        err_sticky  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (host_cfg_wr) begin
            size_x <= host_sizeX;
            size_y <= host_sizeY;
          end
          if (host_start) begin
            if (cfg_bad) begin
              err_sticky <= 1'b1;
            end else begin
              state       <= S_START;
              core_start  <= 1'b1;
              busy        <= 1'b1;
              done_sticky <= 1'b0;
              err_sticky  <= 1'b0;
              zcount      <= '0;
            end
          end
        end
        S_START: begin
          core_start <= 1'b0;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (core_writeZ) zcount <= sat_inc(zcount);
          if (core_done) begin
            state <= S_FINISH;
            busy  <= 1'b0;
            irq   <= 1'b1;
          end
        end
        S_FINISH: begin
          irq         <= 1'b0;
          zcount      <= zcount_fin;
          done_sticky <= 1'b1;
          if (zcount_fin != exp_zcount) err_sticky <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed plus randomized bench for conv_job_sequencer, with behavioural
// memories and a reference model of memory contents and job status.
module tb_conv_job_sequencer;
  localparam int DW = 8;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            host_cfg_wr, host_start, host_clr, host_req, host_we;
  logic [AW-1:0]   host_sizeX, host_sizeY;
  logic [1:0]      host_sel;
  logic [AW:0]     host_addr;
  logic [DW-1:0]   host_wdata;
  logic [2*DW-1:0] host_rdata;
  logic            host_ack, host_nak, busy, done_sticky, err_sticky, irq, core_start;
  logic [2*AW-1:0] core_config;
  logic            core_busy, core_done, core_writeZ;
  logic [AW-1:0]   core_memX_addr, core_memY_addr;
  logic [AW:0]     core_memZ_addr;
  logic [2*DW-1:0] core_dataZ;
  logic [DW-1:0]   core_dataX, core_dataY;
  logic [AW-1:0]   memX_addr, memY_addr;
  logic            memX_we, memY_we, memZ_we;
  logic [DW-1:0]   memX_wdata, memY_wdata, memX_rdata, memY_rdata;
  logic [AW:0]     memZ_addr;
  logic [2*DW-1:0] memZ_wdata, memZ_rdata;

  logic [DW-1:0]   xmem [32];
  logic [DW-1:0]   ymem [32];
  logic [2*DW-1:0] zmem [64];

  logic [DW-1:0]   x_ref [32];
  logic [DW-1:0]   y_ref [32];
  logic [2*DW-1:0] z_ref [64];
  bit              z_valid [64];

  int checks = 0;
  int errors = 0;

  conv_job_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .host_cfg_wr(host_cfg_wr), .host_sizeX(host_sizeX), .host_sizeY(host_sizeY),
    .host_start(host_start), .host_clr(host_clr), .host_req(host_req),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_nak(host_nak), .busy(busy), .done_sticky(done_sticky),
    .err_sticky(err_sticky), .irq(irq), .core_start(core_start),
    .core_config(core_config), .core_busy(core_busy), .core_done(core_done),
    .core_memX_addr(core_memX_addr), .core_memY_addr(core_memY_addr),
    .core_memZ_addr(core_memZ_addr), .core_dataZ(core_dataZ),
    .core_writeZ(core_writeZ), .core_dataX(core_dataX), .core_dataY(core_dataY),
    .memX_addr(memX_addr), .memX_we(memX_we), .memX_wdata(memX_wdata),
    .memX_rdata(memX_rdata), .memY_addr(memY_addr), .memY_we(memY_we),
    .memY_wdata(memY_wdata), .memY_rdata(memY_rdata), .memZ_addr(memZ_addr),
    .memZ_we(memZ_we), .memZ_wdata(memZ_wdata), .memZ_rdata(memZ_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    if (memX_we) xmem[memX_addr] <= memX_wdata;
    if (memY_we) ymem[memY_addr] <= memY_wdata;
    if (memZ_we) zmem[memZ_addr] <= memZ_wdata;
    memX_rdata <= xmem[memX_addr];
    memY_rdata <= ymem[memY_addr];
    memZ_rdata <= zmem[memZ_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_access(input logic we, input logic [1:0] sel, input logic [AW:0] addr,
                             input logic [DW-1:0] wd, input logic exp_nak, input logic chk_rd);
    logic [2*DW-1:0] exp_rd;
    host_req = 1'b1; host_we = we; host_sel = sel; host_addr = addr; host_wdata = wd;
    #1;
    if (exp_nak)
      chk("host_rejected_no_we", 32'({memX_we, memY_we, memZ_we}), 32'd0);
    else if (we)
      chk("host_write_strobe", 32'({memX_we, memY_we, memZ_we}), (sel == 2'd0) ? 32'd4 : 32'd2);
    case (sel)
      2'd0:    exp_rd = {8'h00, x_ref[addr[AW-1:0]]};
      2'd1:    exp_rd = {8'h00, y_ref[addr[AW-1:0]]};
      default: exp_rd = z_ref[addr];
    endcase
    tick();
    host_req = 1'b0; host_we = 1'b0;
    chk("host_ack", 32'(host_ack), 32'd1);
    chk("host_nak", 32'(host_nak), 32'(exp_nak));
    if (chk_rd && !exp_nak && !we) chk("host_rdata", 32'(host_rdata), 32'(exp_rd));
    if (!exp_nak && we) begin
      if (sel == 2'd0) x_ref[addr[AW-1:0]] = wd;
      else y_ref[addr[AW-1:0]] = wd;
    end
  endtask

  // One job: Z write count and FINISH-cycle extras decide the expected error.
  task automatic run_job(input logic [AW-1:0] sx, input logic [AW-1:0] sy, input int nwr,
                         input bit extra, input bit clr_fin, input bit probe);
    int zc;
    int exp_cnt;
    logic [AW:0] za;
    logic [2*DW-1:0] zd;
    host_cfg_wr = 1'b1; host_sizeX = sx; host_sizeY = sy; host_start = 1'b1;
    tick();
    host_cfg_wr = 1'b0; host_start = 1'b0;
    chk("start_pulse", 32'(core_start), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("core_config", 32'(core_config), 32'({sy, sx}));
    tick();
    chk("run_start_low", 32'(core_start), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    if (probe) begin
      host_cfg_wr = 1'b1; host_sizeX = ~sx; host_sizeY = ~sy; host_start = 1'b1;
      core_memX_addr = 5'd3; core_memY_addr = 5'd2;
      host_access(1'b0, 2'd0, 6'd2, 8'h00, 1'b1, 1'b0);
      host_cfg_wr = 1'b0; host_start = 1'b0;
      chk("core_dataX", 32'(core_dataX), 32'(x_ref[3]));
      chk("core_dataY", 32'(core_dataY), 32'(y_ref[2]));
      chk("cfg_ignored_run", 32'(core_config), 32'({sy, sx}));
      chk("start_ignored_run", 32'(core_start), 32'd0);
      host_access(1'b1, 2'd0, 6'd3, 8'hAA, 1'b1, 1'b0);
    end
    zc = 0;
    for (int i = 0; i < nwr; i++) begin
      za = 6'($urandom); zd = 16'($urandom);
      core_memZ_addr = za; core_dataZ = zd; core_writeZ = 1'b1;
      #1;
      chk("core_zwe", 32'({memZ_we, memZ_addr}), 32'({1'b1, za}));
      tick();
      z_ref[za] = zd; z_valid[za] = 1'b1; zc++;
      if (busy !== 1'b1) chk("busy_in_run", 32'(busy), 32'd1);
    end
    core_writeZ = 1'b0; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("finish_irq", 32'(irq), 32'd1);
    chk("finish_busy", 32'(busy), 32'd0);
    if (extra) begin core_writeZ = 1'b1; zc++; end
    if (clr_fin) host_clr = 1'b1;
    tick();
    core_writeZ = 1'b0; host_clr = 1'b0;
    exp_cnt = (zc > 63) ? 63 : zc;
    chk("irq_one_cycle", 32'(irq), 32'd0);
    chk("done_sticky", 32'(done_sticky), 32'd1);
    chk("err_sticky_job", 32'(err_sticky), 32'(exp_cnt != (int'(sx) + int'(sy) - 1)));
  endtask

  initial begin
    logic [1:0] s;
    logic       w;
    logic [AW:0] a;
    logic [AW-1:0] rx, ry;
    int n;
    rst = 1'b1;
    host_cfg_wr = 0; host_sizeX = 0; host_sizeY = 0; host_start = 0; host_clr = 0;
    host_req = 0; host_we = 0; host_sel = 0; host_addr = 0; host_wdata = 0;
    core_busy = 0; core_done = 0; core_memX_addr = 0; core_memY_addr = 0;
    core_memZ_addr = 0; core_dataZ = 0; core_writeZ = 0;
    for (int i = 0; i < 64; i++) begin z_ref[i] = '0; z_valid[i] = 1'b0; end
    tick(); tick();
    chk("rst_outputs", 32'({busy, done_sticky, err_sticky, irq, core_start, host_ack, host_nak}), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_rdata", 32'(host_rdata), 32'd0);
    chk("post_rst_config", 32'(core_config), 32'd0);
    chk("post_rst_core_data", 32'({core_dataX, core_dataY}), 32'd0);

    // Fill X and Y; X[0..3] = 1..4.
    for (int i = 0; i < 32; i++)
      host_access(1'b1, 2'd0, 6'(i), (i < 4) ? 8'(i + 1) : 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 32; i++)
      host_access(1'b1, 2'd1, 6'(i), 8'($urandom), 1'b0, 1'b0);
    host_access(1'b0, 2'd0, 6'd2, 8'h00, 1'b0, 1'b1);
    chk("read_x2_value", 32'(host_rdata), 32'h0003);
    host_access(1'b1, 2'd2, 6'd5, 8'h5A, 1'b1, 1'b0);
    host_access(1'b0, 2'd3, 6'd1, 8'h00, 1'b1, 1'b0);

    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("done_ignored_idle", 32'({irq, busy, done_sticky}), 32'd0);

    run_job(5'd4, 5'd3, 6, 1'b0, 1'b0, 1'b1);

    host_cfg_wr = 1'b1; host_sizeX = 5'd4; host_sizeY = 5'd0;
    tick();
    host_cfg_wr = 1'b0; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("zero_size_err", 32'({err_sticky, core_start, busy}), 32'h4);
    chk("zero_size_done_kept", 32'(done_sticky), 32'd1);
    host_access(1'b0, 2'd0, 6'd1, 8'h00, 1'b0, 1'b1);
    host_clr = 1'b1;
    tick();
    host_clr = 1'b0;
    chk("clr_stickies", 32'({done_sticky, err_sticky}), 32'd0);

    run_job(5'd4, 5'd3, 5, 1'b0, 1'b1, 1'b0);

    host_cfg_wr = 1'b1; host_sizeX = 5'd4; host_sizeY = 5'd3; host_start = 1'b1;
    tick();
    host_cfg_wr = 1'b0; host_start = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_midrun", 32'({busy, done_sticky, err_sticky, irq, core_start}), 32'd0);
    chk("rst_midrun_config", 32'(core_config), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    run_job(5'd4, 5'd3, 6, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      s = 2'($urandom_range(0, 3)); w = 1'($urandom); a = 6'($urandom);
      host_access(w, s, a, 8'($urandom), (s == 2'd3) || (s == 2'd2 && w), (s != 2'd2) || z_valid[a]);
    end

    for (int j = 0; j < 5; j++) begin
      rx = 5'($urandom_range(1, 31)); ry = 5'($urandom_range(1, 31));
      n = int'(rx) + int'(ry) - 1 + $urandom_range(0, 2) - 1;
      if (($urandom % 2) == 1) n = n - 1;
      run_job(rx, ry, n, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 64; i++)
      if (z_valid[i]) host_access(1'b0, 2'd2, 6'(i), 8'h00, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
